// File: rtl/simple_splitter.sv
// Tag-routed demultiplexer: one tagged input stream fanned out to NUM_CHANNELS
// one-entry output slots. Optional drop counter via SIMPLE_SPLITTER_DROP_CNT_EN.
module simple_splitter #(
    parameter int NUM_CHANNELS      = 2,
    parameter int CHANNEL_WIDTH_IN  = 64,
    parameter int CHANNEL_WIDTH_OUT = 32,
    parameter int TAG_MSB           = 55,
    parameter int TAG_LSB           = 48
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [CHANNEL_WIDTH_IN-1:0]           in_data,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    output logic [CHANNEL_WIDTH_OUT*NUM_CHANNELS-1:0] out_data,
    output logic [NUM_CHANNELS-1:0]               out_valid,
    input  logic [NUM_CHANNELS-1:0]               out_ready,
`ifdef SIMPLE_SPLITTER_DROP_CNT_EN
    output logic [15:0]                           drop_count,
    input  logic [0:0]                            drop_clr,
`endif
    output logic                                  tag_error
);

    localparam int TW   = TAG_MSB - TAG_LSB + 1;
    // Compare width wide enough to hold both the tag and NUM_CHANNELS untruncated.
    localparam int CMPW = (TW > 31) ? TW + 1 : 32;
    localparam int OW   = CHANNEL_WIDTH_OUT;

    logic [TW-1:0]                    tag_s;
    logic [CMPW-1:0]                  tag_ext_s;
    logic                             tag_ok_s;
    logic [NUM_CHANNELS-1:0]          free_s;
    logic [NUM_CHANNELS-1:0]          hit_s;
    logic                             free_sel_s;
    logic                             accept_s;
    logic                             unused_in_bits_s;

    logic [NUM_CHANNELS-1:0]          valid_q, valid_d;
    logic [NUM_CHANNELS-1:0][OW-1:0]  data_q, data_d;
    logic                             tag_error_q, tag_error_d;

    assign tag_s            = in_data[TAG_MSB:TAG_LSB];
    assign tag_ext_s        = CMPW'(tag_s);
    assign tag_ok_s         = (tag_ext_s < CMPW'(NUM_CHANNELS));
    assign unused_in_bits_s = ^in_data;

    // Per-slot free flags and selection of the slot addressed by the tag.
    always_comb begin
        free_s     = '0;
        hit_s      = '0;
        free_sel_s = 1'b0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            free_s[k] = !valid_q[k] || out_ready[k];
            if (tag_ext_s == CMPW'(k)) begin
                hit_s[k]   = 1'b1;
                free_sel_s = free_s[k];
            end else begin
                hit_s[k]   = 1'b0;
            end
        end
    end

    // Out-of-range words are always consumed so they can never stall the link.
    assign in_ready = tag_ok_s ? free_sel_s : 1'b1;
    assign accept_s = in_valid && in_ready;

    // Slot next-state: refill wins over drain, so drain+refill keeps the slot valid.
    always_comb begin
        valid_d     = valid_q;
        data_d      = data_q;
        tag_error_d = accept_s && !tag_ok_s;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            if (accept_s && tag_ok_s && hit_s[k]) begin
                valid_d[k] = 1'b1;
                data_d[k]  = in_data[OW-1:0];
            end else if (out_ready[k]) begin
                valid_d[k] = 1'b0;
            end else begin
                valid_d[k] = valid_q[k];
            end
        end
    end

    // Slot and error-pulse registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q     <= '0;
            data_q      <= '0;
            tag_error_q <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            data_q      <= data_d;
            tag_error_q <= tag_error_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign tag_error = tag_error_q;

`ifdef SIMPLE_SPLITTER_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // Saturating drop counter; clear has priority over an increment.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop_clr[0]) begin
            drop_cnt_d = 16'h0000;
        end else if (tag_error_d && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'h0001;
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
    end

    // Drop counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_cnt_q <= 16'h0000;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_simple_splitter.sv
// Self-checking bench for simple_splitter: directed steps followed by random
// traffic, checked against per-channel expected-word queues.
module tb_simple_splitter;

    localparam int NCH = 2;
    localparam int IW  = 64;
    localparam int OW  = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic [IW-1:0]     in_data;
    logic              in_valid;
    logic              in_ready;
    logic [OW*NCH-1:0] out_data;
    logic [NCH-1:0]    out_valid;
    logic [NCH-1:0]    out_ready;
    logic              tag_error;
`ifdef SIMPLE_SPLITTER_DROP_CNT_EN
    logic [15:0]       drop_count;
    logic [0:0]        drop_clr = 1'b0;
    int                exp_drop = 0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [OW-1:0] mq [NCH][$];
    logic          exp_terr = 1'b0;
    logic          seen_ready;

    simple_splitter #(
        .NUM_CHANNELS(NCH), .CHANNEL_WIDTH_IN(IW), .CHANNEL_WIDTH_OUT(OW),
        .TAG_MSB(55), .TAG_LSB(48)
    ) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready),
`ifdef SIMPLE_SPLITTER_DROP_CNT_EN
        .drop_count(drop_count), .drop_clr(drop_clr),
`endif
        .tag_error(tag_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    function automatic logic [IW-1:0] mk(input logic [7:0] t, input logic [OW-1:0] p);
        logic [IW-1:0] w;
        w = {$urandom(), $urandom()};
        w[55:48] = t;
        w[OW-1:0] = p;
        return w;
    endfunction

    task automatic check_outputs();
        for (int k = 0; k < NCH; k++) begin
            check($sformatf("out_valid[%0d]", k), 64'(out_valid[k]), 64'(mq[k].size() != 0));
            if (mq[k].size() != 0)
                check($sformatf("out_data[%0d]", k), 64'(out_data[k*OW +: OW]), 64'(mq[k][0]));
        end
        check("tag_error", 64'(tag_error), 64'(exp_terr));
`ifdef SIMPLE_SPLITTER_DROP_CNT_EN
        check("drop_count", 64'(drop_count), 64'(exp_drop));
`endif
    endtask

    // One clock cycle: drive, check in_ready, advance model, check registered outputs.
    task automatic cyc(input logic v, input logic [IW-1:0] w, input logic [NCH-1:0] ordy);
        int  tg;
        logic exp_rdy;
        logic bad_acc;
        in_valid  = v;
        in_data   = w;
        out_ready = ordy;
        #1;
        tg = int'(w[55:48]);
        exp_rdy = (tg >= NCH) ? 1'b1 : ((mq[tg].size() == 0) || ordy[tg]);
        seen_ready = in_ready;
        if (v) check("in_ready", 64'(in_ready), 64'(exp_rdy));
        for (int k = 0; k < NCH; k++)
            if (mq[k].size() != 0 && ordy[k]) void'(mq[k].pop_front());
        bad_acc = v && exp_rdy && (tg >= NCH);
        if (v && exp_rdy && tg < NCH) mq[tg].push_back(w[OW-1:0]);
        exp_terr = bad_acc;
`ifdef SIMPLE_SPLITTER_DROP_CNT_EN
        if (drop_clr[0]) exp_drop = 0;
        else if (bad_acc && exp_drop < 65535) exp_drop++;
`endif
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic clear_model();
        for (int k = 0; k < NCH; k++) mq[k].delete();
        exp_terr = 1'b0;
`ifdef SIMPLE_SPLITTER_DROP_CNT_EN
        exp_drop = 0;
`endif
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = '0;

        // Reset held for three cycles
        repeat (3) @(posedge clk);
        #1;
        check("rst out_valid", 64'(out_valid), 64'(0));
        check("rst out_data", 64'(out_data), 64'(0));
        check("rst tag_error", 64'(tag_error), 64'(0));
        reset = 1'b1;
        cyc(1'b0, '0, 2'b11);
        cyc(1'b1, mk(8'h00, 32'h1234_5678), 2'b11);
        check("idle in_ready tag0", 64'(seen_ready), 64'(1));

        // Routing to channel 1
        cyc(1'b1, 64'h0001_0000_DEAD_BEEF, 2'b11);
        check("route out_valid", 64'(out_valid), 64'(2'b10));
        check("route data1", 64'(out_data[63:32]), 64'(32'hDEADBEEF));

        // Backpressure on channel 0
        cyc(1'b1, mk(8'h00, 32'hAAAA_0001), 2'b10);
        cyc(1'b1, mk(8'h00, 32'hBBBB_0002), 2'b00);
        check("bp B stalled", 64'(seen_ready), 64'(0));
        check("bp A held", 64'(out_data[31:0]), 64'(32'hAAAA_0001));
        cyc(1'b1, mk(8'h01, 32'hCCCC_0003), 2'b00);
        check("bp C accepted", 64'(seen_ready), 64'(1));
        check("bp both valid", 64'(out_valid), 64'(2'b11));
        cyc(1'b1, mk(8'h00, 32'hBBBB_0002), 2'b01);
        check("bp B accepted", 64'(seen_ready), 64'(1));
        check("bp B loaded", 64'(out_data[31:0]), 64'(32'hBBBB_0002));
        check("bp C held", 64'(out_data[63:32]), 64'(32'hCCCC_0003));

        // Streaming on channel 0
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b1, mk(8'h00, 32'(i)), 2'b01);
            check("stream ready", 64'(seen_ready), 64'(1));
            check("stream data", 64'(out_data[31:0]), 64'(i));
        end

        // Out-of-range tag
        cyc(1'b1, mk(8'h05, 32'h0BAD_0BAD), 2'b00);
        check("bad ready", 64'(seen_ready), 64'(1));
        check("bad pulse", 64'(tag_error), 64'(1));
        cyc(1'b0, '0, 2'b00);
        check("bad pulse end", 64'(tag_error), 64'(0));

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic [7:0] t;
            t = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(2, 255)) : 8'($urandom_range(0, 1));
            cyc(1'($urandom_range(0, 3) != 0), mk(t, $urandom()), 2'($urandom()));
        end

        // Async reset between edges while channel 1 is full
        cyc(1'b1, mk(8'h01, 32'h5555_AAAA), 2'b00);
        check("pre-rst valid1", 64'(out_valid[1]), 64'(1));
        in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("async rst valid", 64'(out_valid), 64'(0));
        check("async rst data", 64'(out_data), 64'(0));
        clear_model();
        @(posedge clk);
        #2 reset = 1'b1;
        cyc(1'b0, '0, 2'b00);
        cyc(1'b0, '0, 2'b11);
        check("post-rst idle", 64'(out_valid), 64'(0));

`ifdef SIMPLE_SPLITTER_DROP_CNT_EN
        // Saturation and clear priority
        for (int i = 0; i < 65540; i++) cyc(1'b1, mk(8'h80, 32'(i)), 2'b11);
        check("drop sat", 64'(drop_count), 64'(16'hFFFF));
        drop_clr = 1'b1;
        cyc(1'b1, mk(8'h07, 32'h0), 2'b11);
        drop_clr = 1'b0;
        check("drop clr wins", 64'(drop_count), 64'(0));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
